// File: rtl/pll_seq_pkg.sv
// Shared state encodings and width helpers for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int unsigned StateW = 3;

    // Sequencer states; encodings are visible on state_o for debug.
    typedef enum logic [StateW-1:0] {
        StRstPll   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } pll_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// Signal suffixes are relative to the sequencer (slave modport).
interface pll_rst_seq_if #(
    parameter int unsigned MAX_RETRY = 3
);
    import pll_seq_pkg::*;

    localparam int unsigned RW = width_for(MAX_RETRY + 1);

    logic                restart_i;
    logic                pll_lock_i;
    logic                pll_rst_o;
    logic                sys_rst_o;
    logic                ready_o;
    logic                fail_o;
    logic [RW-1:0]       retry_o;
    logic [StateW-1:0]   state_o;

    // Sequencer side.
    modport slave (
        input  restart_i, pll_lock_i,
        output pll_rst_o, sys_rst_o, ready_o, fail_o, retry_o, state_o
    );

    // Controller / PLL side.
    modport master (
        output restart_i, pll_lock_i,
        input  pll_rst_o, sys_rst_o, ready_o, fail_o, retry_o, state_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow or asynchronous level signals; clears to 0 on reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back stages; first stage may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// bounded retries, qualifies lock stability, then releases system reset.
// Optional macro PLL_LOCK_FILTER_EN: tolerate up to LOSS_FILTER-1 consecutive
// lock-low cycles in RUN before restarting the sequence.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned LOSS_FILTER    = 4
) (
    input logic          clk,
    input logic          rst,
    pll_rst_seq_if.slave bus
);

`ifdef PLL_LOCK_FILTER_EN
    localparam bit FilterEn = 1'b1;
`else
    localparam bit FilterEn = 1'b0;
`endif

    localparam int unsigned CW = width_for(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam int unsigned RW = width_for(MAX_RETRY + 1);
    // Without the filter a single lock-low cycle in RUN is enough to exit.
    localparam int unsigned LossLimit = FilterEn ? LOSS_FILTER : 1;
    localparam int unsigned FW = width_for(LossLimit);

    localparam logic [CW-1:0] RstLast     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] StableLast  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CntSat      = '1;
    localparam logic [RW-1:0] RetryLast   = RW'(MAX_RETRY - 1);
    localparam logic [FW-1:0] FiltLast    = FW'(LossLimit - 1);

    pll_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [FW-1:0] filt_q, filt_d;
    logic          lock_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pll_lock_i),
        .q_o (lock_s)
    );

    // State, cycle counter, retry counter and lock-loss filter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRstPll;
            cnt_q   <= '0;
            retry_q <= '0;
            filt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            filt_q  <= filt_d;
        end
    end

    // Next-state logic; restart_i overrides every lock/timeout event.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CntSat) ? cnt_q : cnt_q + CW'(1);
        retry_d = retry_q;
        filt_d  = '0;
        if (bus.restart_i) begin
            state_d = StRstPll;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                StRstPll: begin
                    if (cnt_q == RstLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    // Lock seen on the timeout cycle still counts as success.
                    if (lock_s) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        retry_d = retry_q + RW'(1);
                        if (retry_q == RetryLast) begin
                            state_d = StFail;
                        end else begin
                            state_d = StRstPll;
                            cnt_d   = '0;
                        end
                    end
                end
                StStable: begin
                    if (!lock_s) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        if (filt_q == FiltLast) begin
                            state_d = StRstPll;
                            cnt_d   = '0;
                            retry_d = '0;
                        end else begin
                            filt_d = filt_q + FW'(1);
                        end
                    end
                end
                StFail: begin
                    // Sticky until rst or restart_i.
                end
                default: begin
                    state_d = StRstPll;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        bus.pll_rst_o = 1'b0;
        bus.sys_rst_o = 1'b1;
        bus.ready_o   = 1'b0;
        bus.fail_o    = 1'b0;
        case (state_q)
            StRstPll: bus.pll_rst_o = 1'b1;
            StRun: begin
                bus.sys_rst_o = 1'b0;
                bus.ready_o   = 1'b1;
            end
            StFail: begin
                bus.pll_rst_o = 1'b1;
                bus.fail_o    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.retry_o = retry_q;
    assign bus.state_o = state_q;

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Sequences the on-chip PLL macro and derives the system reset from its lock status.
- Runs on the free-running reference-oscillator clock, which is also the PLL refclk.
- Pulses the PLL reset, waits for lock with a timeout and a bounded retry count, and requires lock to be stable before releasing system reset.
- Sits between the board oscillator/PLL and the core/peripheral reset tree; re-runs the sequence on lock loss.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst_o is held high per attempt (minimum 1).
- LOCK_TIMEOUT, 65536: cycles to wait for lock per attempt before a retry.
- STABLE_CYCLES, 1024: consecutive locked cycles required before release.
- MAX_RETRY, 3: number of lock attempts before FAIL (minimum 1).
- LOSS_FILTER, 4: lock-low cycles tolerated in RUN; used only with PLL_LOCK_FILTER_EN.

Ports:
- clk  in  1  reference clock, free-running.
- rst  in  1  synchronous, active-high reset.
- restart_i  in  1  single-cycle soft restart of the sequence.
- pll_lock_i  in  1  PLL lock flag, asynchronous to clk; synchronised internally.
- pll_rst_o  out  1  PLL reset, active-high.
- sys_rst_o  out  1  system reset, active-high; low only in RUN.
- ready_o  out  1  high in RUN.
- fail_o  out  1  high in FAIL.
- retry_o  out  RW  attempts used so far in the current sequence. RW = $clog2(MAX_RETRY+1).
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=1 at a clk edge): state=RST_PLL, cnt=0, retry=0, synchroniser flops=0.
  - Outputs after reset: pll_rst_o=1, sys_rst_o=1, ready_o=0, fail_o=0, retry_o=0.
- pll_lock_i passes through a 2-flop synchroniser to give lock_s. A lock rising edge is seen by the FSM 2 cycles later.
- All outputs are registered, or decoded from the state register only. No combinational path from any input to any output.
- State RST_PLL:
  - pll_rst_o=1, sys_rst_o=1.
  - When cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- State WAIT_LOCK:
  - pll_rst_o=0, sys_rst_o=1.
  - If lock_s=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1 and retry==MAX_RETRY-1: go to FAIL, retry increments to MAX_RETRY.
  - Else if cnt==LOCK_TIMEOUT-1: retry++, go to RST_PLL, cnt=0.
  - Lock and timeout in the same cycle: lock wins.
- State STABLE:
  - pll_rst_o=0, sys_rst_o=1.
  - If lock_s=0: go to WAIT_LOCK, cnt=0, retry unchanged.
  - Else if cnt==STABLE_CYCLES-1: go to RUN.
- State RUN:
  - sys_rst_o=0, ready_o=1.
  - If lock_s=0: go to RST_PLL, cnt=0, retry=0. sys_rst_o rises on the same edge the state leaves RUN.
- State FAIL:
  - pll_rst_o=1, sys_rst_o=1, fail_o=1.
  - Sticky. Exit only via rst or restart_i.
- restart_i in any state: go to RST_PLL, cnt=0, retry=0.
  - Priority: rst > restart_i > lock/timeout events.
- The counter saturates and never wraps. Its width is $clog2 of the maximum of the three cycle parameters.
- Reset mid-operation: returns to the reset state within one cycle, regardless of current state.

Optional Feature:
- Macro: PLL_LOCK_FILTER_EN.
- Defined:
  - In RUN, a separate filter counter counts consecutive lock_s=0 cycles.
  - Exit to RST_PLL only when the count reaches LOSS_FILTER.
  - Any lock_s=1 clears the filter counter.
  - Shorter lock-low glitches are ignored: ready_o stays 1 and sys_rst_o stays 0.
- Undefined: a single lock_s=0 cycle in RUN triggers exit. LOSS_FILTER is unused.

Decomposition:
- Package pll_seq_pkg holds:
  - 3-bit state encodings: RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
  - Width-helper constants.
- Sub-module sync_2ff: parameterised-width two-flop synchroniser, reset to 0. Used here for pll_lock_i and reusable elsewhere.

Test Plan (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, LOSS_FILTER=3):
- Nominal lock:
  - Stimulus: rst for 2 cycles; pll_lock_i=1 at cycle 10 after reset release.
  - Required: pll_rst_o high cycles 0-3; lock_s at cycle 12; STABLE for 8 cycles; sys_rst_o=0 and ready_o=1 from cycle 21; retry_o=0.
- Timeout then retry success:
  - Stimulus: no lock in the first attempt; lock asserted during the second WAIT_LOCK.
  - Required: pll_rst_o re-pulses 4 cycles after 20 WAIT_LOCK cycles; retry_o=1; RUN reached.
- Exhaustion:
  - Stimulus: lock never asserted.
  - Required: after 2 timeouts, FAIL with fail_o=1, retry_o=2, pll_rst_o=1. State held for 100 cycles. restart_i pulse returns to RST_PLL with retry_o=0.
- Lock drop during STABLE:
  - Stimulus: lock low for 1 cycle at STABLE cnt=5.
  - Required: back to WAIT_LOCK; retry unchanged; full 8 stable cycles needed again.
- Lock loss in RUN:
  - Without macro: 1-cycle lock glitch causes sys_rst_o=1 and RST_PLL.
  - With PLL_LOCK_FILTER_EN: a 2-cycle glitch keeps RUN; a 3-cycle low causes exit.
- Priority:
  - Stimulus: rst and restart_i asserted in the same cycle while in RUN.
  - Required: reset state, retry_o=0, counters cleared, sys_rst_o=1 the next cycle.
